id_ex_stage: RTL

//  Decode/issue stage feeding the ALU in the 2-stage MIPS pipeline. Accepts a fetched

---
 rtl/mips_pkg.sv | 34 +++
 rtl/alu_ctrl_decode.sv | 64 ++++++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the 2-stage MIPS pipeline: ALU codes, opcode/funct encodings.
package mips_pkg;

  localparam int unsigned DW_DEFAULT  = 32;
  localparam int unsigned RAW_DEFAULT = 5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_SGT = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Which instruction field names the destination register.
  typedef enum logic [1:0] {DestZero, DestRd, DestRt} dest_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control and operand-select flags.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_signal_o,
  output logic       imm_sel_o,
  output logic       sign_ext_o,
  output logic       reg_write_o,
  output logic       branch_o,
  output dest_sel_e  dest_sel_o,
  output logic       illegal_o
);

  // Decode table; anything not listed is flagged illegal.
  always_comb begin
    alu_signal_o = ALU_ADD;
    imm_sel_o    = 1'b0;
    sign_ext_o   = 1'b0;
    reg_write_o  = 1'b0;
    branch_o     = 1'b0;
    dest_sel_o   = DestZero;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        reg_write_o = 1'b1;
        dest_sel_o  = DestRd;
        case (funct_i)
          FN_ADD:  alu_signal_o = ALU_ADD;
          FN_SUB:  alu_signal_o = ALU_SUB;
          FN_AND:  alu_signal_o = ALU_AND;
          FN_OR:   alu_signal_o = ALU_OR;
          FN_SLL:  alu_signal_o = ALU_SLL;
          FN_SRL:  alu_signal_o = ALU_SRL;
          FN_SLT:  alu_signal_o = ALU_SLT;
          default: begin
            illegal_o   = 1'b1;
            reg_write_o = 1'b0;
            dest_sel_o  = DestZero;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        imm_sel_o   = 1'b1;
        reg_write_o = 1'b1;
        dest_sel_o  = DestRt;
        sign_ext_o  = (opcode_i == OP_ADDI) || (opcode_i == OP_SLTI);
        case (opcode_i)
          OP_SLTI: alu_signal_o = ALU_SLT;
          OP_ANDI: alu_signal_o = ALU_AND;
          OP_ORI:  alu_signal_o = ALU_OR;
          default: alu_signal_o = ALU_ADD;
        endcase
      end
      OP_BEQ: begin
        alu_signal_o = ALU_SUB;
        branch_o     = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes, forwards writeback data, and registers ALU operands
// into a single handshaked pipeline slot.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEFAULT,
  parameter int unsigned RAW = RAW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  input  logic           flush,
  input  logic           wb_en,
  input  logic [RAW-1:0] wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [2:0]     alu_signal,
  output logic [4:0]     alu_shiftamt,
  output logic [RAW-1:0] dest_addr,
  output logic           reg_write,
  output logic           branch,
  output logic           illegal_op
);

  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [15:0] imm;
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign rd_addr = instr[15:11];
  assign shamt   = instr[10:6];
  assign imm     = instr[15:0];

  logic [2:0] dec_signal;
  logic       dec_imm_sel, dec_sign_ext, dec_reg_write, dec_branch, dec_illegal;
  dest_sel_e  dec_dest_sel;

  alu_ctrl_decode u_decode (
    .opcode_i     (instr[31:26]),
    .funct_i      (instr[5:0]),
    .alu_signal_o (dec_signal),
    .imm_sel_o    (dec_imm_sel),
    .sign_ext_o   (dec_sign_ext),
    .reg_write_o  (dec_reg_write),
    .branch_o     (dec_branch),
    .dest_sel_o   (dec_dest_sel),
    .illegal_o    (dec_illegal)
  );

  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]     alu_signal_q, alu_signal_d;
  logic [4:0]     alu_shiftamt_q, alu_shiftamt_d;
  logic [RAW-1:0] dest_addr_q, dest_addr_d;
  logic           reg_write_q, reg_write_d;
  logic           branch_q, branch_d;
  logic           illegal_op_q, illegal_op_d;

  logic           accept, is_shift;
  logic [DW-1:0]  rs_fwd, rt_fwd, imm_ext;
  logic [RAW-1:0] dest_sel_addr;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand forwarding, immediate extension and destination selection.
  always_comb begin
    rs_fwd  = (wb_en && (wb_addr != '0) && (wb_addr == RAW'(rs_addr))) ? wb_data : rs_data;
    rt_fwd  = (wb_en && (wb_addr != '0) && (wb_addr == RAW'(rt_addr))) ? wb_data : rt_data;
    imm_ext = {{(DW-16){dec_sign_ext & imm[15]}}, imm};
    is_shift = (dec_signal == ALU_SLL) || (dec_signal == ALU_SRL);
    unique case (dec_dest_sel)
      DestRd:  dest_sel_addr = RAW'(rd_addr);
      DestRt:  dest_sel_addr = RAW'(rt_addr);
      default: dest_sel_addr = '0;
    endcase
  end

  // Slot next state: flush beats accept and hold; illegal accepts load a bubble.
  always_comb begin
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_signal_d   = alu_signal_q;
    alu_shiftamt_d = alu_shiftamt_q;
    dest_addr_d    = dest_addr_q;
    reg_write_d    = reg_write_q;
    branch_d       = branch_q;
    out_valid_d    = out_valid_q;
    if (accept) begin
      // Shifts operate on rt; b is unused by the shifter and held at zero.
      alu_a_d        = is_shift ? rt_fwd : rs_fwd;
      alu_b_d        = is_shift ? '0 : (dec_imm_sel ? imm_ext : rt_fwd);
      alu_signal_d   = dec_signal;
      alu_shiftamt_d = is_shift ? shamt : 5'd0;
      dest_addr_d    = dest_sel_addr;
      reg_write_d    = dec_reg_write && (dest_sel_addr != '0);
      branch_d       = dec_branch;
    end
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = !dec_illegal;
    else if (out_ready) out_valid_d = 1'b0;
    illegal_op_d = accept && dec_illegal && !flush;
  end

  // Slot register, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_signal_q   <= ALU_ADD;
      alu_shiftamt_q <= '0;
      dest_addr_q    <= '0;
      reg_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      illegal_op_q   <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_signal_q   <= alu_signal_d;
      alu_shiftamt_q <= alu_shiftamt_d;
      dest_addr_q    <= dest_addr_d;
      reg_write_q    <= reg_write_d;
      branch_q       <= branch_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_signal   = alu_signal_q;
  assign alu_shiftamt = alu_shiftamt_q;
  assign dest_addr    = dest_addr_q;
  assign reg_write    = reg_write_q;
  assign branch       = branch_q;
  assign illegal_op   = illegal_op_q;

endmodule
